// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: shared flag/entry types and widths for the ALU result stage
package alu_stage_pkg;
  localparam int FLAG_W = 4;
  localparam int RD_W = 5;
  localparam int RES_W = 64;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [RD_W-1:0] rd;
  } alu_entry_t;
endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular buffer of {result, rd} with valid/ready on both sides
// ports: clk, reset (async, high); in_valid/in_ready/in_result/in_rd push side;
// out_valid/out_ready/out_result/out_rd pop side (outputs 0 when empty); count
module alu_result_fifo
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [RD_W-1:0]            in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [RD_W-1:0]            out_rd,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [RD_W-1:0] rd_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  // in_ready looks only at occupancy, so a full buffer refuses a push even while popping
  assign in_ready = count < FULL;
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_result = out_valid ? res_mem[rd_ptr] : '0;
  assign out_rd = out_valid ? rd_mem[rd_ptr] : '0;
  // DEPTH is a power of two, so pointer wrap is the natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        rd_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        res_mem[wr_ptr] <= in_result;
        rd_mem[wr_ptr] <= in_rd;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: registered ALU result FIFO plus architectural N/Z/V/C flag register
// ports: clk, reset (async, high); in_* ALU result, rd, flags, set_flags with
// in_valid/in_ready; out_* writeback handshake; flags {N,Z,V,C}; count occupancy
// ALU_FLAG_FWD_EN: when defined, flags forwards incoming flags combinationally on a
// flag-setting push; otherwise flags is purely the register output
module alu_flag_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [RD_W-1:0]            in_rd,
  input  logic                       in_negative,
  input  logic                       in_zero,
  input  logic                       in_overflow,
  input  logic                       in_carry_out,
  input  logic                       in_set_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [RD_W-1:0]            out_rd,
  output logic [FLAG_W-1:0]          flags,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  alu_flags_t flags_q, in_flags;
  logic load;
  assign in_flags = '{n: in_negative, z: in_zero, v: in_overflow, c: in_carry_out};
  // flags commit at acceptance, independent of when the entry is popped
  assign load = in_valid && in_ready && in_set_flags;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else flags_q <= load ? in_flags : flags_q;
  end
`ifdef ALU_FLAG_FWD_EN
  assign flags = load ? in_flags : flags_q;
`else
  assign flags = flags_q;
`endif
  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_rd(in_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_rd(out_rd),
    .count(count)
  );
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: table-driven, scoreboarded check of alu_flag_stage
module tb_alu_flag_stage;
  import alu_stage_pkg::*;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] in_result = '0;
  logic [4:0] in_rd = '0;
  logic in_negative = 1'b0, in_zero = 1'b0, in_overflow = 1'b0, in_carry_out = 1'b0;
  logic in_set_flags = 1'b0;
  logic out_valid, out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0] out_rd;
  logic [3:0] flags;
  logic [CW-1:0] count;
  typedef struct {
    logic iv;
    logic [63:0] res;
    logic [4:0] rd;
    logic [3:0] nzvc;
    logic sf;
    logic ordy;
    int cnt;
    logic [3:0] fl;
  } vec_t;
  vec_t tv [16];
  alu_entry_t q [$];
  logic [3:0] mflags = '0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  alu_flag_stage #(.WIDTH(64), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_rd(in_rd),
    .in_negative(in_negative),
    .in_zero(in_zero),
    .in_overflow(in_overflow),
    .in_carry_out(in_carry_out),
    .in_set_flags(in_set_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_rd(out_rd),
    .flags(flags),
    .count(count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input vec_t v);
    logic acc, pop;
    logic [3:0] ef;
    in_valid = v.iv;
    in_result = v.res;
    in_rd = v.rd;
    {in_negative, in_zero, in_overflow, in_carry_out} = v.nzvc;
    in_set_flags = v.sf;
    out_ready = v.ordy;
    #1;
    acc = v.iv && (q.size() < DEPTH);
    pop = (q.size() > 0) && v.ordy;
    ef = mflags;
`ifdef ALU_FLAG_FWD_EN
    if (acc && v.sf) ef = v.nzvc;
`endif
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, q.size() > 0);
    chk("count", count, q.size());
    chk("flags_pre", flags, ef);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_rd", out_rd, q[0].rd);
    end else begin
      chk("out_result_idle", out_result, 0);
      chk("out_rd_idle", out_rd, 0);
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{result: v.res, rd: v.rd});
      if (v.sf) mflags = v.nzvc;
    end
    @(posedge clk);
    #1;
    chk("count_post", count, v.cnt);
    chk("flags_post", flags, v.fl);
  endtask
  initial begin
    tv[0]  = '{1'b1, 64'h5, 5'd3, 4'h0, 1'b0, 1'b1, 1, 4'h0};
    tv[1]  = '{1'b0, 64'h0, 5'd0, 4'h0, 1'b0, 1'b1, 0, 4'h0};
    tv[2]  = '{1'b1, 64'hA, 5'd1, 4'h0, 1'b0, 1'b0, 1, 4'h0};
    tv[3]  = '{1'b1, 64'hB, 5'd2, 4'h0, 1'b0, 1'b0, 2, 4'h0};
    tv[4]  = '{1'b1, 64'hC, 5'd4, 4'hF, 1'b1, 1'b0, 2, 4'h0};
    tv[5]  = '{1'b1, 64'hC, 5'd4, 4'hF, 1'b1, 1'b1, 1, 4'h0};
    tv[6]  = '{1'b1, 64'hD, 5'd5, 4'h0, 1'b0, 1'b1, 1, 4'h0};
    tv[7]  = '{1'b1, 64'hE, 5'd6, 4'hA, 1'b1, 1'b1, 1, 4'hA};
    tv[8]  = '{1'b1, 64'hF, 5'd7, 4'h4, 1'b0, 1'b0, 2, 4'hA};
    tv[9]  = '{1'b0, 64'h0, 5'd0, 4'h0, 1'b0, 1'b1, 1, 4'hA};
    tv[10] = '{1'b0, 64'h0, 5'd0, 4'h0, 1'b0, 1'b1, 0, 4'hA};
    tv[11] = '{1'b0, 64'h0, 5'd0, 4'h0, 1'b1, 1'b1, 0, 4'hA};
    tv[12] = '{1'b1, 64'hDEAD_BEEF_0123_4567, 5'd31, 4'h5, 1'b1, 1'b0, 1, 4'h5};
    tv[13] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 4'hA, 1'b0, 1'b0, 2, 4'h5};
    tv[14] = '{1'b1, 64'h77, 5'd9, 4'h0, 1'b0, 1'b1, 1, 4'h0};
    tv[15] = '{1'b0, 64'h0, 5'd0, 4'h0, 1'b0, 1'b1, 0, 4'h0};
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_flags", flags, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 14) begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_out_result", out_result, 0);
        q.delete();
        mflags = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      step(tv[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
